// File: rtl/opb_register_bank_pkg.sv
// Shared register map, bit positions and helpers for the multi-channel
// simulink-to-PPC register bank.
package opb_register_bank_pkg;

    localparam logic [31:0] CTRL_OFFSET    = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFFSET  = 32'h0000_0004;
    localparam logic [31:0] CH_BASE_OFFSET = 32'h0000_0008;

    localparam int CTRL_MODE_BIT    = 0;
    localparam int CTRL_SW_SNAP_BIT = 1;
    localparam int STATUS_NEW_BIT   = 31;
    localparam int SNAP_CNT_W       = 16;

    function automatic logic [31:0] status_word(input logic [SNAP_CNT_W-1:0] cnt,
                                                input logic new_flag);
        logic [31:0] w;
        w = '0;
        w[SNAP_CNT_W-1:0] = cnt;
        w[STATUS_NEW_BIT] = new_flag;
        return w;
    endfunction

endpackage

// File: rtl/reg_snapshot_bank.sv
// Snapshot engine: strobe edge detect, per-channel capture registers,
// wrapping snapshot counter and sticky NEW flag (set beats clear).
module reg_snapshot_bank
    import opb_register_bank_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [NUM_CH*CH_WIDTH-1:0]   data_in,
    input  logic                         user_snap,
    input  logic                         sw_snap,
    input  logic                         new_clr,
    output logic [NUM_CH*CH_WIDTH-1:0]   cap_data,
    output logic [SNAP_CNT_W-1:0]        snap_cnt,
    output logic                         new_flag
);

    logic                  snap_prev_q, snap_prev_d;
    logic [SNAP_CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic                  new_q, new_d;
    logic                  snap_ev;

    assign snap_ev = (user_snap & ~snap_prev_q) | sw_snap;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cap
            logic [CH_WIDTH-1:0] cap_q, cap_d;

            always_comb begin
                cap_d = cap_q;
                if (snap_ev) begin
                    cap_d = data_in[gi*CH_WIDTH +: CH_WIDTH];
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    cap_q <= '0;
                end else begin
                    cap_q <= cap_d;
                end
            end

            assign cap_data[gi*CH_WIDTH +: CH_WIDTH] = cap_q;
        end
    endgenerate

    always_comb begin
        snap_prev_d = user_snap;
        snap_cnt_d  = snap_cnt_q + SNAP_CNT_W'(snap_ev);
        new_d       = new_q;
        // A snapshot landing on the same cycle as a STATUS read must not be lost.
        if (snap_ev) begin
            new_d = 1'b1;
        end else if (new_clr) begin
            new_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            snap_prev_q <= 1'b0;
            snap_cnt_q  <= '0;
            new_q       <= 1'b0;
        end else begin
            snap_prev_q <= snap_prev_d;
            snap_cnt_q  <= snap_cnt_d;
            new_q       <= new_d;
        end
    end

    assign snap_cnt = snap_cnt_q;
    assign new_flag = new_q;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave window exposing C_NUM_CH user words, live or snapshotted,
// plus CTRL and clear-on-read STATUS registers.
module opb_register_bank_simulink2ppc
    import opb_register_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108_3A00,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108_3AFF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_CH_WIDTH   = 32
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    output logic [0:31]                      Sl_DBus,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    output logic                             Sl_xferAck,
    input  logic [0:31]                      OPB_ABus,
    input  logic [0:3]                       OPB_BE,
    input  logic [0:31]                      OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    input  logic [C_NUM_CH*C_CH_WIDTH-1:0]   user_data_in,
    input  logic                             user_snap
);

    logic [C_OPB_AWIDTH-1:0]        addr;
    logic [31:0]                    off;
    logic [31:0]                    off_w;
    logic                           hit;
    logic                           access;
    logic                           wr_ctrl;
    logic                           sw_snap;
    logic                           rd_status;

    logic                           ack_q, ack_d;
    logic                           hit_prev_q, hit_prev_d;
    logic [C_OPB_DWIDTH-1:0]        dbus_q, dbus_d;
    logic [7:0]                     ctrl_q, ctrl_d;
    logic [C_NUM_CH*C_CH_WIDTH-1:0] live_q, live_d;

    logic [C_NUM_CH*C_CH_WIDTH-1:0] cap_data;
    logic [C_NUM_CH*C_CH_WIDTH-1:0] chan_src;
    logic [SNAP_CNT_W-1:0]          snap_cnt;
    logic                           new_flag;
    logic [C_OPB_DWIDTH-1:0]        rdata;

    assign addr  = OPB_ABus;
    assign hit   = OPB_select & (addr >= C_BASEADDR) & (addr <= C_HIGHADDR);
    assign off   = addr - C_BASEADDR;
    assign off_w = {off[31:2], 2'b00};

    // One ack per select assertion: a hit still present from before (including
    // across reset) must drop before another transfer is accepted.
    assign access    = hit & ~ack_q & ~hit_prev_q;
    assign wr_ctrl   = access & ~OPB_RNW & (off_w == CTRL_OFFSET) & OPB_BE[3];
    assign sw_snap   = wr_ctrl & OPB_DBus[30];
    assign rd_status = access & OPB_RNW & (off_w == STATUS_OFFSET);

    reg_snapshot_bank #(
        .NUM_CH   (C_NUM_CH),
        .CH_WIDTH (C_CH_WIDTH)
    ) u_snap (
        .clk       (OPB_Clk),
        .srst      (OPB_Rst),
        .data_in   (user_data_in),
        .user_snap (user_snap),
        .sw_snap   (sw_snap),
        .new_clr   (rd_status),
        .cap_data  (cap_data),
        .snap_cnt  (snap_cnt),
        .new_flag  (new_flag)
    );

    assign chan_src = ctrl_q[CTRL_MODE_BIT] ? cap_data : live_q;

    always_comb begin
        rdata = '0;
        if (off_w == CTRL_OFFSET) begin
            rdata = C_OPB_DWIDTH'(ctrl_q);
        end else if (off_w == STATUS_OFFSET) begin
            rdata = status_word(snap_cnt, new_flag);
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (off_w == CH_BASE_OFFSET + 32'(4 * i)) begin
                    rdata = C_OPB_DWIDTH'(chan_src[i*C_CH_WIDTH +: C_CH_WIDTH]);
                end
            end
        end
    end

    always_comb begin
        ack_d      = access;
        hit_prev_d = hit;
        dbus_d     = (access & OPB_RNW) ? rdata : '0;
        live_d     = user_data_in;
        ctrl_d     = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d                   = OPB_DBus[24:31];
            ctrl_d[CTRL_SW_SNAP_BIT] = 1'b0;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ack_q      <= 1'b0;
            hit_prev_q <= 1'b1;
            dbus_q     <= '0;
            ctrl_q     <= '0;
            live_q     <= '0;
        end else begin
            ack_q      <= ack_d;
            hit_prev_q <= hit_prev_d;
            dbus_q     <= dbus_d;
            ctrl_q     <= ctrl_d;
            live_q     <= live_d;
        end
    end

    assign Sl_xferAck = ack_q;
    assign Sl_DBus    = dbus_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, OPB_seqAddr, off[1:0], OPB_BE[0:2], OPB_DBus[0:23]};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Self-checking bench: table of live-read/write vectors, scoreboard of
// expected read data popped on every ack, plus snapshot corner sequences.
module tb_opb_register_bank_simulink2ppc;

    localparam logic [31:0] BASE = 32'h0108_3A00;
    localparam logic [31:0] HIGH = 32'h0108_3AFF;

    logic         clk = 1'b0;
    logic         srst;
    always #5 clk = ~clk;

    // main instance: 4 x 32
    logic [0:31]  abus, wbus, rd;
    logic [0:3]   be;
    logic         rnw, sel, seq_a, usnap;
    logic [127:0] din;
    logic         err, retry, tout, ack;

    // second instance: 2 x 12
    logic [0:31]  abus2, wbus2, rd2;
    logic [0:3]   be2;
    logic         rnw2, sel2, seq2, usnap2;
    logic [23:0]  din2;
    logic         err2, retry2, tout2, ack2;

    opb_register_bank_simulink2ppc dut (
        .OPB_Clk(clk), .OPB_Rst(srst), .Sl_DBus(rd), .Sl_errAck(err),
        .Sl_retry(retry), .Sl_toutSup(tout), .Sl_xferAck(ack),
        .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(wbus), .OPB_RNW(rnw),
        .OPB_select(sel), .OPB_seqAddr(seq_a), .user_data_in(din),
        .user_snap(usnap)
    );

    opb_register_bank_simulink2ppc #(.C_NUM_CH(2), .C_CH_WIDTH(12)) dut2 (
        .OPB_Clk(clk), .OPB_Rst(srst), .Sl_DBus(rd2), .Sl_errAck(err2),
        .Sl_retry(retry2), .Sl_toutSup(tout2), .Sl_xferAck(ack2),
        .OPB_ABus(abus2), .OPB_BE(be2), .OPB_DBus(wbus2), .OPB_RNW(rnw2),
        .OPB_select(sel2), .OPB_seqAddr(seq2), .user_data_in(din2),
        .user_snap(usnap2)
    );

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        string        name;
        logic         rnw;
        logic [7:0]   off;
        logic [31:0]  wdata;
        logic [127:0] din;
        logic [31:0]  exp;
    } vec_t;

    sb_t  q1[$];
    sb_t  q2[$];
    sb_t  m1, m2;
    vec_t vecs[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Every ack pops one expected read word; outside acks the bus must be 0.
    always @(negedge clk) begin
        if (ack) begin
            if (q1.size() == 0) begin
                check("dut unexpected ack", 32'd1, 32'd0);
            end else begin
                m1 = q1.pop_front();
                check(m1.name, rd, m1.exp);
            end
        end else if (rd !== 32'h0) begin
            check("dut dbus idle", rd, 32'h0);
        end
        if (ack2) begin
            if (q2.size() == 0) begin
                check("dut2 unexpected ack", 32'd1, 32'd0);
            end else begin
                m2 = q2.pop_front();
                check(m2.name, rd2, m2.exp);
            end
        end else if (rd2 !== 32'h0) begin
            check("dut2 dbus idle", rd2, 32'h0);
        end
    end

    task automatic bus1(input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input logic [31:0] exp, input string name,
                        input logic snap_now);
        sb_t e;
        int  lat;
        e.exp  = r ? exp : 32'h0;
        e.name = name;
        q1.push_back(e);
        @(negedge clk);
        sel = 1'b1; abus = a; rnw = r; wbus = wd; be = b;
        if (snap_now) usnap = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        check({name, " latency"}, 32'(lat), 32'd1);
        sel = 1'b0; abus = '0; rnw = 1'b0; wbus = '0; be = '0; usnap = 1'b0;
    endtask

    task automatic bus2_held(input logic [31:0] a, input logic exp_ack,
                             input logic [31:0] exp, input string name);
        sb_t e;
        int  nack;
        e.exp  = exp;
        e.name = name;
        if (exp_ack) q2.push_back(e);
        @(negedge clk);
        sel2 = 1'b1; abus2 = a;
        nack = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack2) nack++;
        end
        sel2 = 1'b0; abus2 = '0;
        check({name, " ack count"}, 32'(nack), exp_ack ? 32'd1 : 32'd0);
    endtask

    task automatic pulse_snap();
        @(negedge clk); usnap = 1'b1;
        @(negedge clk); usnap = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nack;
        vecs[0] = '{"live ch0",      1'b1, 8'h08, 32'h0, {96'h0, 32'hDEADBEEF},            32'hDEADBEEF};
        vecs[1] = '{"live ch3",      1'b1, 8'h14, 32'h0, {32'hA5A55A5A, 96'h0},            32'hA5A55A5A};
        vecs[2] = '{"live ch1",      1'b1, 8'h0C, 32'h0, {64'h0, 32'h00000001, 32'hFFFF}, 32'h00000001};
        vecs[3] = '{"past last ch",  1'b1, 8'h18, 32'h0, {4{32'hFFFFFFFF}},                32'h0};
        vecs[4] = '{"top of window", 1'b1, 8'hFC, 32'h0, {4{32'hFFFFFFFF}},                32'h0};
        vecs[5] = '{"wr ctrl 0",     1'b0, 8'h00, 32'h0, 128'h0,                           32'h0};
        vecs[6] = '{"wr status",     1'b0, 8'h04, 32'h1, 128'h0,                           32'h0};
        vecs[7] = '{"status idle",   1'b1, 8'h04, 32'h0, 128'h0,                           32'h0};

        srst = 1'b1;
        abus = '0; wbus = '0; be = '0; rnw = 1'b0; sel = 1'b0; seq_a = 1'b0; usnap = 1'b0; din = '0;
        abus2 = '0; wbus2 = '0; be2 = '0; rnw2 = 1'b1; sel2 = 1'b0; seq2 = 1'b0; usnap2 = 1'b0;
        din2 = {12'hABC, 12'hFFF};
        repeat (3) @(negedge clk);
        srst = 1'b0;

        check("reset ack", 32'(ack), 32'd0);
        check("reset dbus", rd, 32'h0);
        check("tied outputs", {29'h0, err, retry, tout}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            din = vecs[i].din;
            bus1(vecs[i].rnw, BASE + 32'(vecs[i].off), vecs[i].wdata, 4'hF,
                 vecs[i].exp, vecs[i].name, 1'b0);
        end

        // snapshot mode, hardware strobe
        bus1(1'b0, BASE, 32'h1, 4'hF, 32'h0, "wr ctrl mode", 1'b0);
        din = {64'h0, 32'h1234, 32'h0};
        pulse_snap();
        din = {64'h0, 32'h5678, 32'h0};
        bus1(1'b1, BASE + 32'h0C, 32'h0, 4'hF, 32'h00001234, "snap ch1", 1'b0);
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h80000001, "status new", 1'b0);
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h00000001, "status cleared", 1'b0);

        // software trigger; BE[3] gating
        bus1(1'b0, BASE, 32'h3, 4'hF, 32'h0, "wr ctrl sw snap", 1'b0);
        bus1(1'b1, BASE, 32'h0, 4'hF, 32'h00000001, "ctrl readback", 1'b0);
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h80000002, "status sw snap", 1'b0);
        bus1(1'b0, BASE, 32'h2, 4'b1110, 32'h0, "wr ctrl no be3", 1'b0);
        bus1(1'b1, BASE, 32'h0, 4'hF, 32'h00000001, "ctrl after no be3", 1'b0);
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h00000002, "status no be3", 1'b0);

        // level held for 10 cycles counts once
        @(negedge clk); usnap = 1'b1;
        repeat (10) @(negedge clk);
        usnap = 1'b0;
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h80000003, "status held strobe", 1'b0);

        // counter wrap
        @(negedge clk); force dut.u_snap.snap_cnt_q = 16'hFFFF;
        @(negedge clk); release dut.u_snap.snap_cnt_q;
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h0000FFFF, "status forced", 1'b0);
        pulse_snap();
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h80000000, "status wrap", 1'b0);

        // strobe coincident with the STATUS clear: old value returned, NEW survives
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h00000000, "status coincident", 1'b1);
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h80000001, "status set wins", 1'b0);

        // strobe coincident with a channel read
        din = {64'h0, 32'h1111, 32'h0};
        pulse_snap();
        din = {64'h0, 32'h2222, 32'h0};
        bus1(1'b1, BASE + 32'h0C, 32'h0, 4'hF, 32'h00001111, "ch1 coincident old", 1'b1);
        bus1(1'b1, BASE + 32'h0C, 32'h0, 4'hF, 32'h00002222, "ch1 after snap", 1'b0);

        // back to live mode
        bus1(1'b0, BASE, 32'h0, 4'hF, 32'h0, "wr ctrl live", 1'b0);
        din = {64'h0, 32'h3333, 32'h0};
        bus1(1'b1, BASE + 32'h0C, 32'h0, 4'hF, 32'h00003333, "ch1 live again", 1'b0);
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h80000003, "status count", 1'b0);

        // reset while a read is pending; select stays high across reset
        @(negedge clk);
        sel = 1'b1; abus = BASE + 32'h08; rnw = 1'b1; srst = 1'b1;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        nack = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) nack++;
        end
        check("reset held select acks", 32'(nack), 32'd0);
        sel = 1'b0; abus = '0; rnw = 1'b0;
        bus1(1'b1, BASE, 32'h0, 4'hF, 32'h0, "ctrl after reset", 1'b0);
        bus1(1'b1, BASE + 32'h04, 32'h0, 4'hF, 32'h0, "status after reset", 1'b0);
        din = {96'h0, 32'hCAFEF00D};
        bus1(1'b1, BASE + 32'h08, 32'h0, 4'hF, 32'hCAFEF00D, "ch0 after reset", 1'b0);

        // narrow instance with select held 5 cycles
        bus2_held(BASE + 32'h10, 1'b1, 32'h0, "n2 past ch");
        bus2_held(BASE + 32'h08, 1'b1, 32'h00000FFF, "n2 ch0");
        bus2_held(BASE + 32'h0C, 1'b1, 32'h00000ABC, "n2 ch1");
        bus2_held(HIGH + 32'h4, 1'b0, 32'h0, "n2 above window");
        bus2_held(BASE - 32'h4, 1'b0, 32'h0, "n2 below window");

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(q1.size() + q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
